// File: rtl/debounce_sync.sv
// Resynchronises a raw asynchronous level into the clk domain and debounces it.
// The output level, rise and fall pulses are registered and feed the downstream D_FF.
module debounce_sync #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall,
    output logic busy
);

    typedef enum logic [1:0] {
        ST_LO,
        CHK_HI,
        ST_HI,
        CHK_LO
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic [SYNC_STAGES-1:0] sync;
    logic                   s;

    // Only the last synchroniser stage is allowed to reach the FSM.
    assign s = sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], din};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_LO;
            cnt   <= '0;
            dout  <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            unique case (state)
                ST_LO: begin
                    if (s) begin
                        state <= CHK_HI;
                        cnt   <= CNT_ONE;
                    end else begin
                        cnt <= '0;
                    end
                end
                CHK_HI: begin
                    if (!s) begin
                        state <= ST_LO;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= ST_HI;
                        dout  <= 1'b1;
                        rise  <= 1'b1;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                ST_HI: begin
                    if (!s) begin
                        state <= CHK_LO;
                        cnt   <= CNT_ONE;
                    end else begin
                        cnt <= '0;
                    end
                end
                CHK_LO: begin
                    if (s) begin
                        state <= ST_HI;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= ST_LO;
                        dout  <= 1'b0;
                        fall  <= 1'b1;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= ST_LO;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign busy = (state == CHK_HI) || (state == CHK_LO);

endmodule

// File: tb/tb_debounce_sync.sv
// Self-checking bench for debounce_sync: hand-derived vector table plus corner-case sequences.
// Expected {dout, rise, fall, busy} per edge is queued on drive and compared after the edge.
module tb_debounce_sync;

    logic clk;
    logic reset;
    logic din;
    logic dout;
    logic rise;
    logic fall;
    logic busy;

    typedef struct packed {
        logic       din;
        logic [3:0] exp;
    } vector_t;

    vector_t    vecs[$];
    logic [3:0] sb[$];
    int         checks = 0;
    int         errors = 0;

    debounce_sync #(
        .SYNC_STAGES  (2),
        .STABLE_CYCLES(4),
        .CNT_W        (8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .din  (din),
        .dout (dout),
        .rise (rise),
        .fall (fall),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag);
        logic [3:0] expv;
        logic [3:0] act;
        act = {dout, rise, fall, busy};
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("[TB] FAIL %s actual=%b required=queued expectation", tag, act);
        end else begin
            expv = sb.pop_front();
            if (act !== expv) begin
                errors++;
                $display("[TB] FAIL %s actual dout,rise,fall,busy=%b required=%b", tag, act, expv);
            end
        end
    endtask

    task automatic applyStimulus(input logic rst_v, input logic din_v,
                                 input logic [3:0] exp_v, input string tag);
        @(negedge clk);
        reset = rst_v;
        din   = din_v;
        sb.push_back(exp_v);
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    task automatic addVec(input logic d, input logic [3:0] e);
        vecs.push_back('{din: d, exp: e});
    endtask

    initial begin
        reset = 1'b1;
        din   = 1'b0;

        // Expectations are {dout, rise, fall, busy} after each edge, starting from idle low.
        // Clean rise: din captured at first edge, busy from edge 3, dout/rise at edge 6.
        addVec(1, 4'b0000); addVec(1, 4'b0000); addVec(1, 4'b0001); addVec(1, 4'b0001);
        addVec(1, 4'b0001); addVec(1, 4'b1100); addVec(1, 4'b1000);
        // Two-cycle low glitch while high: busy pulses, no fall.
        addVec(0, 4'b1000); addVec(0, 4'b1000); addVec(1, 4'b1001); addVec(1, 4'b1001);
        addVec(1, 4'b1000); addVec(1, 4'b1000); addVec(1, 4'b1000);
        // Held low: fall six edges after capture.
        addVec(0, 4'b1000); addVec(0, 4'b1000); addVec(0, 4'b1001); addVec(0, 4'b1001);
        addVec(0, 4'b1001); addVec(0, 4'b0010); addVec(0, 4'b0000);
        // Bounce 1,0,1,0 then hold high: single rise on the 4th stable sample.
        addVec(1, 4'b0000); addVec(0, 4'b0000); addVec(1, 4'b0001); addVec(0, 4'b0000);
        addVec(1, 4'b0001); addVec(1, 4'b0000); addVec(1, 4'b0001); addVec(1, 4'b0001);
        addVec(1, 4'b0001); addVec(1, 4'b1100); addVec(1, 4'b1000);
        // Fall again then a clean rise with the same latency.
        addVec(0, 4'b1000); addVec(0, 4'b1000); addVec(0, 4'b1001); addVec(0, 4'b1001);
        addVec(0, 4'b1001); addVec(0, 4'b0010); addVec(1, 4'b0000); addVec(1, 4'b0000);
        addVec(1, 4'b0001); addVec(1, 4'b0001); addVec(1, 4'b0001); addVec(1, 4'b1100);
        addVec(1, 4'b1000);

        applyStimulus(1, 0, 4'b0000, "reset0");
        applyStimulus(1, 0, 4'b0000, "reset1");
        for (int i = 0; i < 20; i++) applyStimulus(0, 0, 4'b0000, $sformatf("idle%0d", i));

        for (int i = 0; i < vecs.size(); i++)
            applyStimulus(0, vecs[i].din, vecs[i].exp, $sformatf("vec%0d", i));

        // Reset while high with din held 1: release behaves as a fresh 0->1 transition.
        applyStimulus(1, 1, 4'b0000, "rst_high");
        applyStimulus(0, 1, 4'b0000, "rel1_e1");
        applyStimulus(0, 1, 4'b0000, "rel1_e2");
        applyStimulus(0, 1, 4'b0001, "rel1_e3");
        applyStimulus(0, 1, 4'b0001, "rel1_e4");
        applyStimulus(0, 1, 4'b0001, "rel1_e5");
        applyStimulus(0, 1, 4'b1100, "rel1_e6");
        applyStimulus(0, 1, 4'b1000, "rel1_e7");

        // Reset in CHK_HI with cnt=2: qualification abandoned, no rise, restarts after release.
        applyStimulus(1, 0, 4'b0000, "rst_low");
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 4'b0000, $sformatf("low%0d", i));
        applyStimulus(0, 1, 4'b0000, "mid_e1");
        applyStimulus(0, 1, 4'b0000, "mid_e2");
        applyStimulus(0, 1, 4'b0001, "mid_e3");
        applyStimulus(0, 1, 4'b0001, "mid_e4");
        applyStimulus(1, 1, 4'b0000, "mid_reset");
        applyStimulus(0, 1, 4'b0000, "rst_e1");
        applyStimulus(0, 1, 4'b0000, "rst_e2");
        applyStimulus(0, 1, 4'b0001, "rst_e3");
        applyStimulus(0, 1, 4'b0001, "rst_e4");
        applyStimulus(0, 1, 4'b0001, "rst_e5");
        applyStimulus(0, 1, 4'b1100, "rst_e6");
        applyStimulus(0, 1, 4'b1000, "rst_e7");

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard_drain actual=%0d left required=0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/debounce_sync.md
Name: debounce_sync

Overview:
- Conditioning stage that sits directly upstream of the team's D_FF and produces its D input.
- Takes a raw asynchronous level (button, switch or external pin) and resynchronises it into the clk domain through a flop chain.
- Filters glitches by requiring a number of consecutive stable samples before the output follows the input.
- Emits one-cycle rise and fall pulses alongside the clean level.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops; legal range 2..4.
- STABLE_CYCLES, 4, consecutive identical synchronised samples required to accept a new level; legal range 2..(2^CNT_W - 1).
- CNT_W, 8, stability counter width; must satisfy 2^CNT_W > STABLE_CYCLES.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high; sampled on the rising edge of clk.
- din  input  1  raw asynchronous input level.
- dout  output  1  debounced, synchronised level (registered); feeds D_FF.D.
- rise  output  1  one-cycle pulse, asserted in the same cycle dout goes 0->1 (registered).
- fall  output  1  one-cycle pulse, asserted in the same cycle dout goes 1->0 (registered).
- busy  output  1  high while a candidate transition is being qualified (state CHK_HI or CHK_LO).

Behaviour:
- Reset (clk edge with reset=1):
  - all sync flops = 0, cnt = 0, state = ST_LO, dout = 0, rise = 0, fall = 0.
  - Reset overrides everything, including a qualification in progress, which is abandoned with no pulse.
- Synchroniser:
  - sync[0] <= din; sync[i] <= sync[i-1].
  - s = sync[SYNC_STAGES-1].
  - The FSM only ever looks at s, never at din directly.
- FSM, 4 states, one sample of s per clk edge:
  - ST_LO (dout=0):
    - s=1 -> CHK_HI, cnt <= 1.
    - otherwise stay, cnt <= 0.
  - CHK_HI (dout=0):
    - s=0 -> ST_LO, cnt <= 0, no pulse.
    - s=1 and cnt == STABLE_CYCLES-1 -> ST_HI, dout <= 1, rise <= 1, cnt <= 0.
    - s=1 otherwise -> cnt <= cnt+1.
  - ST_HI (dout=1):
    - s=0 -> CHK_LO, cnt <= 1.
    - otherwise stay.
  - CHK_LO: mirror of CHK_HI. s=1 aborts to ST_HI; qualification completes with dout <= 0, fall <= 1.
- Pulses:
  - rise and fall default to 0 every cycle and are high for exactly one cycle.
  - rise and fall are never high together.
  - No pulse is generated on an aborted qualification.
- Latency:
  - Count the edge at which din is first captured into sync[0] as edge 1, with din held stable from then on.
  - dout (and rise/fall) update at edge SYNC_STAGES + STABLE_CYCLES. Defaults: edge 6.
- Glitch rejection:
  - Any run of s shorter than STABLE_CYCLES samples leaves dout unchanged.
  - An aborted run restarts the count from 1 on the next opposite sample.
- cnt never exceeds STABLE_CYCLES-1; no wrap.
- After reset release with din held 1:
  - treated as a genuine 0->1 transition; dout rises after the normal latency, with a rise pulse.
- busy is combinational from state, registered only through state; 0 in reset.

Test Plan (10 ns clock, default parameters):
- Reset, then din=0 for 20 cycles -> dout=0, rise=fall=busy=0 throughout.
- Reset released, din 0->1 captured at edge k and held -> busy high from edge k+2; dout=1 and rise=1 at edge k+5; rise=0 at k+6; D_FF.Q follows one edge later.
- With dout=1, din low for 2 cycles then back high -> busy pulses, dout stays 1, fall never asserted.
- din bounces 1,0,1,0,1 on consecutive cycles then holds 1 -> exactly one rise pulse, at the 4th consecutive high sample of s.
- dout=1, then din=0 held -> fall=1 and dout=0 exactly SYNC_STAGES+STABLE_CYCLES edges after capture; then 0->1 again produces rise with the same latency.
- reset asserted mid-qualification (state CHK_HI, cnt=2) -> next edge: dout=0, busy=0, cnt=0, no rise pulse; qualification restarts after release.
